// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, ALUOp codes,
// FSM state codes, instruction classes and the control-word layout.
package mips_ctrl_pkg;

    localparam logic [5:0] OPC_R    = 6'h00;
    localparam logic [5:0] OPC_J    = 6'h02;
    localparam logic [5:0] OPC_JAL  = 6'h03;
    localparam logic [5:0] OPC_BEQ  = 6'h04;
    localparam logic [5:0] OPC_BNE  = 6'h05;
    localparam logic [5:0] OPC_ADDI = 6'h08;
    localparam logic [5:0] OPC_ANDI = 6'h0C;
    localparam logic [5:0] OPC_ORI  = 6'h0D;
    localparam logic [5:0] OPC_LUI  = 6'h0F;
    localparam logic [5:0] OPC_LW   = 6'h23;
    localparam logic [5:0] OPC_SW   = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_LUI   = 3'b011;
    localparam logic [2:0] ALU_ADDI  = 3'b100;
    localparam logic [2:0] ALU_ORI   = 3'b101;
    localparam logic [2:0] ALU_ANDI  = 3'b110;
    localparam logic [2:0] ALU_FUNCT = 3'b111;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_WB_R     = 4'd4;
    localparam logic [3:0] S_EXEC_I   = 4'd5;
    localparam logic [3:0] S_WB_I     = 4'd6;
    localparam logic [3:0] S_MEM_ADDR = 4'd7;
    localparam logic [3:0] S_MEM_RD   = 4'd8;
    localparam logic [3:0] S_WB_MEM   = 4'd9;
    localparam logic [3:0] S_MEM_WR   = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;
    localparam logic [3:0] S_TRAP     = 4'd13;

    typedef enum logic [3:0] {
        CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_J, CLS_JAL, CLS_ILL
    } instr_class_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       branch_eq;
        logic       branch_ne;
        logic [2:0] alu_op;
        logic       illegal_op;
        logic       retire;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Opcode/handshake inputs and datapath control outputs of the multicycle control unit.
interface multicycle_control_if #(
    parameter int OP_WIDTH     = 6,
    parameter int ALU_OP_WIDTH = 3
);
    logic [OP_WIDTH-1:0]     OP;
    logic                    mem_ready;
    logic                    PCWrite;
    logic                    PCWriteCond;
    logic                    IorD;
    logic                    IRWrite;
    logic                    MemRead;
    logic                    MemWrite;
    logic                    MemtoReg;
    logic                    RegWrite;
    logic [1:0]              RegDst;
    logic                    ALUSrcA;
    logic [1:0]              ALUSrcB;
    logic [1:0]              PCSource;
    logic                    BranchEQ;
    logic                    BranchNE;
    logic [ALU_OP_WIDTH-1:0] ALUOp;
    logic                    illegal_op;
    logic                    retire;

    modport master (
        output OP, mem_ready,
        input  PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
               RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, BranchEQ, BranchNE,
               ALUOp, illegal_op, retire
    );

    modport slave (
        input  OP, mem_ready,
        output PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
               RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, BranchEQ, BranchNE,
               ALUOp, illegal_op, retire
    );
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational opcode classifier: instruction class plus the ALUOp used by I-type execute.
module control_decode
    import mips_ctrl_pkg::*;
#(
    parameter int OP_WIDTH   = 6,
    parameter bit ENABLE_JAL = 1'b1
) (
    input  logic [OP_WIDTH-1:0] op,
    output instr_class_e        cls,
    output logic [2:0]          alu_i_op
);

    always_comb begin
        cls      = CLS_ILL;
        alu_i_op = ALU_ADD;
        case (op)
            OP_WIDTH'(OPC_R):    cls = CLS_R;
            OP_WIDTH'(OPC_ADDI): begin cls = CLS_I; alu_i_op = ALU_ADDI; end
            OP_WIDTH'(OPC_ORI):  begin cls = CLS_I; alu_i_op = ALU_ORI;  end
            OP_WIDTH'(OPC_ANDI): begin cls = CLS_I; alu_i_op = ALU_ANDI; end
            OP_WIDTH'(OPC_LUI):  begin cls = CLS_I; alu_i_op = ALU_LUI;  end
            OP_WIDTH'(OPC_LW):   cls = CLS_LW;
            OP_WIDTH'(OPC_SW):   cls = CLS_SW;
            OP_WIDTH'(OPC_BEQ):  cls = CLS_BEQ;
            OP_WIDTH'(OPC_BNE):  cls = CLS_BNE;
            OP_WIDTH'(OPC_J):    cls = CLS_J;
            OP_WIDTH'(OPC_JAL):  cls = ENABLE_JAL ? CLS_JAL : CLS_ILL;
            default:             cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences each instruction and drives datapath enables/muxes.
//  state    | meaning
//  IDLE     | after reset, all outputs low
//  FETCH    | read instruction; IR/PC written on the mem_ready cycle
//  DECODE   | classify OP, compute branch target
//  EXEC_R   | R-type ALU op          WB_R   | write rd
//  EXEC_I   | immediate ALU op       WB_I   | write rt
//  MEM_ADDR | effective address      MEM_RD | load wait   WB_MEM | write loaded rt
//  MEM_WR   | store wait, retires on mem_ready
//  BRANCH   | BEQ/BNE compare and conditional PC write
//  JUMP     | J/JAL; JAL links $ra
//  TRAP     | one-cycle illegal_op flag
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OP_WIDTH     = 6,
    parameter int ALU_OP_WIDTH = 3,
    parameter bit ENABLE_JAL   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.slave  bus
);

    logic [3:0]   state_q, state_d;
    instr_class_e cls_q, cls_d;
    logic [2:0]   alu_i_q, alu_i_d;
    instr_class_e dec_cls;
    logic [2:0]   dec_alu;
    ctrl_t        ctl;

    control_decode #(.OP_WIDTH(OP_WIDTH), .ENABLE_JAL(ENABLE_JAL)) u_decode (
        .op       (bus.OP),
        .cls      (dec_cls),
        .alu_i_op (dec_alu)
    );

    // OP is only trusted in DECODE, so the class is captured there for later states.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        alu_i_d = alu_i_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                cls_d   = dec_cls;
                alu_i_d = dec_alu;
                case (dec_cls)
                    CLS_R:            state_d = S_EXEC_R;
                    CLS_I:            state_d = S_EXEC_I;
                    CLS_LW, CLS_SW:   state_d = S_MEM_ADDR;
                    CLS_BEQ, CLS_BNE: state_d = S_BRANCH;
                    CLS_J, CLS_JAL:   state_d = S_JUMP;
                    default:          state_d = S_TRAP;
                endcase
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            S_MEM_ADDR: state_d = (cls_q == CLS_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (bus.mem_ready) state_d = S_WB_MEM;
            S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_TRAP: state_d = S_FETCH;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cls_q   <= CLS_ILL;
            alu_i_q <= ALU_ADD;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            alu_i_q <= alu_i_d;
        end
    end

    // Only IR/PC write in FETCH and the store retire are qualified by mem_ready,
    // so each fires exactly once per access however long memory stalls.
    always_comb begin
        ctl = '0;
        case (state_q)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'b01;
                ctl.ir_write  = bus.mem_ready;
                ctl.pc_write  = bus.mem_ready;
            end
            S_DECODE: ctl.alu_src_b = 2'b11;
            S_EXEC_R: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = ALU_FUNCT;
            end
            S_WB_R: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 2'b01;
                ctl.retire    = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = 2'b10;
                ctl.alu_op    = (state_q == S_EXEC_I) ? alu_i_q : ALU_ADD;
            end
            S_WB_I: begin
                ctl.reg_write = 1'b1;
                ctl.retire    = 1'b1;
            end
            S_MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
            end
            S_WB_MEM: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                ctl.retire     = 1'b1;
            end
            S_MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
                ctl.retire    = bus.mem_ready;
            end
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_op        = ALU_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = 2'b01;
                ctl.branch_eq     = (cls_q == CLS_BEQ);
                ctl.branch_ne     = (cls_q == CLS_BNE);
                ctl.retire        = 1'b1;
            end
            S_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = 2'b10;
                ctl.retire    = 1'b1;
                if (cls_q == CLS_JAL) begin
                    ctl.reg_write = 1'b1;
                    ctl.reg_dst   = 2'b10;
                end
            end
            S_TRAP:  ctl.illegal_op = 1'b1;
            default: ctl = '0;
        endcase
    end

    assign bus.PCWrite     = ctl.pc_write;
    assign bus.PCWriteCond = ctl.pc_write_cond;
    assign bus.IorD        = ctl.iord;
    assign bus.IRWrite     = ctl.ir_write;
    assign bus.MemRead     = ctl.mem_read;
    assign bus.MemWrite    = ctl.mem_write;
    assign bus.MemtoReg    = ctl.mem_to_reg;
    assign bus.RegWrite    = ctl.reg_write;
    assign bus.RegDst      = ctl.reg_dst;
    assign bus.ALUSrcA     = ctl.alu_src_a;
    assign bus.ALUSrcB     = ctl.alu_src_b;
    assign bus.PCSource    = ctl.pc_source;
    assign bus.BranchEQ    = ctl.branch_eq;
    assign bus.BranchNE    = ctl.branch_ne;
    assign bus.ALUOp       = ALU_OP_WIDTH'(ctl.alu_op);
    assign bus.illegal_op  = ctl.illegal_op;
    assign bus.retire      = ctl.retire;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (JAL enabled / disabled) driven in lockstep
// and compared every cycle against a per-instruction expected-cycle model.
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       branch_eq;
        logic       branch_ne;
        logic [2:0] alu_op;
        logic       illegal_op;
        logic       retire;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_if #(.OP_WIDTH(6), .ALU_OP_WIDTH(3)) bus0 ();
    multicycle_control_if #(.OP_WIDTH(6), .ALU_OP_WIDTH(3)) bus1 ();

    multicycle_control #(.OP_WIDTH(6), .ALU_OP_WIDTH(3), .ENABLE_JAL(1'b1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    multicycle_control #(.OP_WIDTH(6), .ALU_OP_WIDTH(3), .ENABLE_JAL(1'b0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    exp_t obs0, obs1;
    assign obs0 = {bus0.PCWrite, bus0.PCWriteCond, bus0.IorD, bus0.IRWrite, bus0.MemRead,
                   bus0.MemWrite, bus0.MemtoReg, bus0.RegWrite, bus0.RegDst, bus0.ALUSrcA,
                   bus0.ALUSrcB, bus0.PCSource, bus0.BranchEQ, bus0.BranchNE, bus0.ALUOp,
                   bus0.illegal_op, bus0.retire};
    assign obs1 = {bus1.PCWrite, bus1.PCWriteCond, bus1.IorD, bus1.IRWrite, bus1.MemRead,
                   bus1.MemWrite, bus1.MemtoReg, bus1.RegWrite, bus1.RegDst, bus1.ALUSrcA,
                   bus1.ALUSrcB, bus1.PCSource, bus1.BranchEQ, bus1.BranchNE, bus1.ALUOp,
                   bus1.illegal_op, bus1.retire};

    int   total = 0;
    int   bad   = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic mrq[$];

    task automatic check(input string tag, input exp_t o, input exp_t e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
        total++;
        assert (!(o.mem_read && o.mem_write) && !(o.pc_write && o.pc_write_cond)) else begin
            bad++;
            $error("FAIL %s_excl observed=%h expected=no MemRead&MemWrite, no PCWrite&PCWriteCond", tag, o);
        end
    endtask

    task automatic step(input logic rst, input logic [5:0] op, input logic mr,
                        input exp_t e0, input exp_t e1, input string tag);
        @(negedge clk);
        reset          = rst;
        bus0.OP        = op;
        bus1.OP        = op;
        bus0.mem_ready = mr;
        bus1.mem_ready = mr;
        #1;
        check({tag, "/jal_on"}, obs0, e0);
        check({tag, "/jal_off"}, obs1, e1);
    endtask

    function automatic logic [5:0] junk_op();
        return 6'($urandom);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic exp_t e_fetch(input logic mr);
        exp_t c = '0;
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.ir_write  = mr;
        c.pc_write  = mr;
        return c;
    endfunction

    function automatic exp_t e_decode();
        exp_t c = '0;
        c.alu_src_b = 2'b11;
        return c;
    endfunction

    function automatic exp_t e_mem(input logic is_load, input logic done_store);
        exp_t c = '0;
        c.iord      = 1'b1;
        c.mem_read  = is_load;
        c.mem_write = !is_load;
        c.retire    = done_store;
        return c;
    endfunction

    task automatic push(input exp_t a, input exp_t b, input logic mr);
        q0.push_back(a);
        q1.push_back(b);
        mrq.push_back(mr);
    endtask

    // Expected cycles after DECODE for one instruction; mw = memory wait cycles.
    task automatic add_body(input logic [5:0] opc, input int mw);
        exp_t c;
        exp_t d;
        c = '0;
        d = '0;
        case (opc)
            6'h00: begin
                c.alu_src_a = 1'b1; c.alu_op = 3'b111; push(c, c, rnd_bit());
                c = '0; c.reg_write = 1'b1; c.reg_dst = 2'b01; c.retire = 1'b1;
                push(c, c, rnd_bit());
            end
            6'h08, 6'h0C, 6'h0D, 6'h0F: begin
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                c.alu_op = (opc == 6'h08) ? 3'b100 : (opc == 6'h0D) ? 3'b101 :
                           (opc == 6'h0C) ? 3'b110 : 3'b011;
                push(c, c, rnd_bit());
                c = '0; c.reg_write = 1'b1; c.reg_dst = 2'b00; c.retire = 1'b1;
                push(c, c, rnd_bit());
            end
            6'h23, 6'h2B: begin
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 3'b000;
                push(c, c, rnd_bit());
                for (int i = 0; i < mw; i++) push(e_mem(opc == 6'h23, 1'b0), e_mem(opc == 6'h23, 1'b0), 1'b0);
                push(e_mem(opc == 6'h23, opc == 6'h2B), e_mem(opc == 6'h23, opc == 6'h2B), 1'b1);
                if (opc == 6'h23) begin
                    c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.retire = 1'b1;
                    push(c, c, rnd_bit());
                end
            end
            6'h04, 6'h05: begin
                c.alu_src_a = 1'b1; c.alu_op = 3'b001; c.pc_write_cond = 1'b1;
                c.pc_source = 2'b01; c.branch_eq = (opc == 6'h04); c.branch_ne = (opc == 6'h05);
                c.retire = 1'b1;
                push(c, c, rnd_bit());
            end
            6'h02: begin
                c.pc_write = 1'b1; c.pc_source = 2'b10; c.retire = 1'b1;
                push(c, c, rnd_bit());
            end
            6'h03: begin
                c.pc_write = 1'b1; c.pc_source = 2'b10; c.retire = 1'b1;
                c.reg_write = 1'b1; c.reg_dst = 2'b10;
                d.illegal_op = 1'b1;
                push(c, d, rnd_bit());
            end
            default: begin
                c.illegal_op = 1'b1;
                push(c, c, rnd_bit());
            end
        endcase
    endtask

    task automatic run_instr(input logic [5:0] opc, input int fw, input int mw);
        string tag;
        int    n;
        for (int i = 0; i < fw; i++)
            step(1'b0, junk_op(), 1'b0, e_fetch(1'b0), e_fetch(1'b0), $sformatf("op%02h/fetch_wait%0d", opc, i));
        step(1'b0, junk_op(), 1'b1, e_fetch(1'b1), e_fetch(1'b1), $sformatf("op%02h/fetch", opc));
        step(1'b0, opc, rnd_bit(), e_decode(), e_decode(), $sformatf("op%02h/decode", opc));
        add_body(opc, mw);
        n = 0;
        while (q0.size() > 0) begin
            tag = $sformatf("op%02h/body%0d", opc, n);
            step(1'b0, junk_op(), mrq.pop_front(), q0.pop_front(), q1.pop_front(), tag);
            n++;
        end
    endtask

    initial begin
        logic [5:0] ops [11];
        logic [5:0] opc;
        ops = '{6'h00, 6'h08, 6'h0D, 6'h0C, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

        reset          = 1'b1;
        bus0.OP        = '0;
        bus1.OP        = '0;
        bus0.mem_ready = 1'b0;
        bus1.mem_ready = 1'b0;
        @(posedge clk);
        step(1'b1, junk_op(), rnd_bit(), '0, '0, "reset_a");
        step(1'b0, junk_op(), rnd_bit(), '0, '0, "idle");

        run_instr(6'h08, 0, 0);
        run_instr(6'h23, 0, 3);
        run_instr(6'h05, 0, 0);
        run_instr(6'h03, 0, 0);
        run_instr(6'h3F, 0, 0);
        run_instr(6'h00, 2, 0);
        run_instr(6'h2B, 1, 2);
        run_instr(6'h04, 0, 0);
        run_instr(6'h02, 0, 0);
        run_instr(6'h0D, 0, 0);
        run_instr(6'h0C, 0, 0);
        run_instr(6'h0F, 0, 0);

        // Reset landing in the middle of a load wait.
        step(1'b0, junk_op(), 1'b1, e_fetch(1'b1), e_fetch(1'b1), "rst_mid/fetch");
        step(1'b0, 6'h23, rnd_bit(), e_decode(), e_decode(), "rst_mid/decode");
        add_body(6'h23, 0);
        step(1'b0, junk_op(), rnd_bit(), q0[0], q1[0], "rst_mid/addr");
        q0.delete(); q1.delete(); mrq.delete();
        step(1'b0, junk_op(), 1'b0, e_mem(1'b1, 1'b0), e_mem(1'b1, 1'b0), "rst_mid/wait");
        step(1'b1, junk_op(), 1'b0, e_mem(1'b1, 1'b0), e_mem(1'b1, 1'b0), "rst_mid/rst_edge");
        step(1'b1, junk_op(), 1'b1, '0, '0, "rst_mid/held");
        step(1'b0, junk_op(), 1'b1, '0, '0, "rst_mid/idle");
        run_instr(6'h2B, 0, 0);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 5) == 0) opc = junk_op();
            else                          opc = ops[$urandom_range(0, 10)];
            run_instr(opc, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
